// File: rtl/timer_pkg.sv
// Shared constants and FSM encoding for the 60 s timer's key conditioning path.
package timer_pkg;

  localparam int unsigned CLK_FREQ_HZ   = 12_000_000;
  localparam int unsigned CYCLES_PER_MS = CLK_FREQ_HZ / 1000;

  localparam int unsigned DB_MS   = 20;
  localparam int unsigned LONG_MS = 1000;

  localparam int unsigned DB_CYCLES_DEF   = DB_MS * CYCLES_PER_MS;
  localparam int unsigned LONG_CYCLES_DEF = LONG_MS * CYCLES_PER_MS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } key_state_e;

endpackage

// File: rtl/key_pause_ctrl_if.sv
// Key input and timer-control outputs of key_pause_ctrl, bundled for the testbench and the top.
interface key_pause_ctrl_if;
  logic key_in;
  logic key_level;
  logic pause_out;
  logic clear_out;
  logic run_state;

  modport master (
    output key_in,
    input  key_level, pause_out, clear_out, run_state
  );

  modport slave (
    input  key_in,
    output key_level, pause_out, clear_out, run_state
  );
endinterface

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus stable-count debouncer; key_level is 1 while the key is pressed.
module key_debounce
  import timer_pkg::*;
#(
  parameter int unsigned DB_CYCLES      = DB_CYCLES_DEF,
  parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic key_in,
  output logic key_level
);

  localparam int unsigned       DB_W     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DB_CYCLES - 1);
  // Raw pin level meaning "not pressed"; synchroniser resets to it.
  localparam logic              IDLE_RAW = KEY_ACTIVE_LOW;

  logic            sync1_q, sync2_q;
  logic            key_s;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            key_level_q, key_level_d;

  assign key_s = sync2_q ^ KEY_ACTIVE_LOW;

  always_comb begin
    db_cnt_d    = '0;
    key_level_d = key_level_q;
    if (key_s != key_level_q) begin
      if (db_cnt_q == DB_LAST) begin
        key_level_d = key_s;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync1_q     <= IDLE_RAW;
      sync2_q     <= IDLE_RAW;
      db_cnt_q    <= '0;
      key_level_q <= 1'b0;
    end else begin
      sync1_q     <= key_in;
      sync2_q     <= sync1_q;
      db_cnt_q    <= db_cnt_d;
      key_level_q <= key_level_d;
    end
  end

  assign key_level = key_level_q;

endmodule

// File: rtl/key_pause_ctrl.sv
// Classifies debounced presses as short (pause pulse) or long (clear pulse) and tracks run/pause.
//  state | meaning
//  IDLE  | key released, waiting for a press
//  HELD  | key pressed, counting toward a long press
//  LONG  | long press already reported, waiting for release
module key_pause_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned DB_CYCLES      = DB_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES    = LONG_CYCLES_DEF,
  parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  key_pause_ctrl_if.slave  kif
);

  localparam int unsigned       HOLD_W    = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  logic              key_level;
  key_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              run_state_q, run_state_d;
  logic              pause_q, pause_d;
  logic              clear_q, clear_d;

  key_debounce #(
    .DB_CYCLES      (DB_CYCLES),
    .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
  ) u_debounce (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .key_in    (kif.key_in),
    .key_level (key_level)
  );

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    run_state_d = run_state_q;
    pause_d     = 1'b0;
    clear_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (key_level) begin
          state_d    = ST_HELD;
          hold_cnt_d = '0;
        end
      end
      ST_HELD: begin
        // Release is tested first so a release on the last count is still a short press.
        if (!key_level) begin
          pause_d     = 1'b1;
          run_state_d = ~run_state_q;
          state_d     = ST_IDLE;
        end else if (hold_cnt_q == HOLD_LAST) begin
          clear_d     = 1'b1;
          run_state_d = 1'b0;
          state_d     = ST_LONG;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      ST_LONG: begin
        if (!key_level) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      hold_cnt_q  <= '0;
      run_state_q <= 1'b0;
      pause_q     <= 1'b0;
      clear_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      run_state_q <= run_state_d;
      pause_q     <= pause_d;
      clear_q     <= clear_d;
    end
  end

  assign kif.key_level = key_level;
  assign kif.pause_out = pause_q;
  assign kif.clear_out = clear_q;
  assign kif.run_state = run_state_q;

endmodule

// File: tb/tb_key_pause_ctrl.sv
// Directed bench for key_pause_ctrl with DB_CYCLES=4, LONG_CYCLES=20, active-low key.
module tb_key_pause_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  key_pause_ctrl_if kif();

  key_pause_ctrl #(
    .DB_CYCLES      (4),
    .LONG_CYCLES    (20),
    .KEY_ACTIVE_LOW (1'b1)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .kif    (kif.slave)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   pause_cnt = 0;
  int   clear_cnt = 0;
  int   both_cnt = 0;
  int   double_cnt = 0;
  logic prev_pause = 1'b0;
  logic prev_clear = 1'b0;
  logic level_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (kif.pause_out === 1'b1) pause_cnt++;
    if (kif.clear_out === 1'b1) clear_cnt++;
    if (kif.pause_out === 1'b1 && kif.clear_out === 1'b1) both_cnt++;
    if ((kif.pause_out === 1'b1 && prev_pause) || (kif.clear_out === 1'b1 && prev_clear)) double_cnt++;
    prev_pause = (kif.pause_out === 1'b1);
    prev_clear = (kif.clear_out === 1'b1);
    if (kif.key_level === 1'b1) level_seen = 1'b1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr_counts();
    pause_cnt  = 0;
    clear_cnt  = 0;
    level_seen = 1'b0;
  endtask

  initial begin
    kif.key_in = 1'b1;
    rst = 1'b1;
    ticks(3);
    rst = 1'b0;
    chk("rst_key_level", kif.key_level, 0);
    chk("rst_pause", kif.pause_out, 0);
    chk("rst_clear", kif.clear_out, 0);
    chk("rst_run", kif.run_state, 0);
    clr_counts();
    ticks(50);
    chk("idle_pause_cnt", pause_cnt, 0);
    chk("idle_clear_cnt", clear_cnt, 0);
    chk("idle_level_seen", level_seen, 0);

    // Short press: key_level rises 6 edges after the pin falls, pause 7 edges after release.
    clr_counts();
    kif.key_in = 1'b0;
    ticks(5);
    chk("short_level_early", kif.key_level, 0);
    tick();
    chk("short_level_rise", kif.key_level, 1);
    ticks(4);
    kif.key_in = 1'b1;
    ticks(6);
    chk("short_level_fall", kif.key_level, 0);
    chk("short_no_pause_yet", kif.pause_out, 0);
    tick();
    chk("short_pause", kif.pause_out, 1);
    chk("short_run", kif.run_state, 1);
    tick();
    chk("short_pause_one_cycle", kif.pause_out, 0);
    ticks(10);
    chk("short_pause_cnt", pause_cnt, 1);
    chk("short_clear_cnt", clear_cnt, 0);

    clr_counts();
    kif.key_in = 1'b0;
    ticks(10);
    kif.key_in = 1'b1;
    ticks(20);
    chk("short2_run", kif.run_state, 0);
    chk("short2_pause_cnt", pause_cnt, 1);

    // Bounce: 2-cycle low runs never survive the 4-cycle debounce.
    clr_counts();
    for (int i = 0; i < 5; i++) begin
      kif.key_in = 1'b0;
      ticks(2);
      kif.key_in = 1'b1;
      ticks(2);
    end
    ticks(20);
    chk("bounce_level_seen", level_seen, 0);
    chk("bounce_pause_cnt", pause_cnt, 0);
    chk("bounce_clear_cnt", clear_cnt, 0);

    kif.key_in = 1'b0;
    ticks(10);
    kif.key_in = 1'b1;
    ticks(20);
    chk("prelong_run", kif.run_state, 1);

    // Long press: level up at a+6, HELD from a+7, clear at a+27.
    clr_counts();
    kif.key_in = 1'b0;
    ticks(26);
    chk("long_no_clear_yet", kif.clear_out, 0);
    tick();
    chk("long_clear", kif.clear_out, 1);
    chk("long_run", kif.run_state, 0);
    tick();
    chk("long_clear_one_cycle", kif.clear_out, 0);
    ticks(12);
    kif.key_in = 1'b1;
    ticks(20);
    chk("long_pause_cnt", pause_cnt, 0);
    chk("long_clear_cnt", clear_cnt, 1);
    chk("long_level", kif.key_level, 0);

    // 21 cycles low: key_level still high when hold_cnt==19 -> clear.
    clr_counts();
    kif.key_in = 1'b0;
    ticks(21);
    kif.key_in = 1'b1;
    ticks(6);
    chk("b21_clear", kif.clear_out, 1);
    ticks(20);
    chk("b21_pause_cnt", pause_cnt, 0);
    chk("b21_clear_cnt", clear_cnt, 1);
    chk("b21_run", kif.run_state, 0);

    // 20 cycles low: key_level falls as hold_cnt reaches 19 -> release wins.
    clr_counts();
    kif.key_in = 1'b0;
    ticks(20);
    kif.key_in = 1'b1;
    ticks(7);
    chk("b20_pause", kif.pause_out, 1);
    chk("b20_no_clear", kif.clear_out, 0);
    chk("b20_run", kif.run_state, 1);
    ticks(20);
    chk("b20_pause_cnt", pause_cnt, 1);
    chk("b20_clear_cnt", clear_cnt, 0);

    // Reset while held: key must re-debounce and be released before pausing.
    clr_counts();
    kif.key_in = 1'b0;
    ticks(10);
    chk("mid_held_level", kif.key_level, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_level", kif.key_level, 0);
    chk("mid_rst_run", kif.run_state, 0);
    chk("mid_rst_pause", kif.pause_out, 0);
    ticks(5);
    chk("mid_level_early", kif.key_level, 0);
    tick();
    chk("mid_level_rise", kif.key_level, 1);
    ticks(4);
    chk("mid_no_pause_held", pause_cnt, 0);
    kif.key_in = 1'b1;
    ticks(7);
    chk("mid_pause", kif.pause_out, 1);
    chk("mid_run", kif.run_state, 1);
    ticks(10);
    chk("mid_pause_cnt", pause_cnt, 1);
    chk("mid_clear_cnt", clear_cnt, 0);

    chk("never_both", both_cnt, 0);
    chk("never_double", double_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
